// File: rtl/atp_payment_accumulator.sv
// Payment accumulator for the ATP controller: totals accepted notes against
// the bill due and issues a validate, or a refund on cancel/timeout.
module atp_payment_accumulator #(
   parameter int AMT_W       = 16,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [AMT_W-1:0] due_amount,
   input  logic             cancel,
   input  logic             note_valid,
   input  logic [AMT_W-1:0] note_value,
   output logic             note_ready,
   output logic             note_reject,
   output logic [AMT_W-1:0] paid_total,
   output logic             validate_payment,
   output logic             payment_failed,
   output logic [AMT_W-1:0] change_amount,
   output logic [AMT_W-1:0] refund_amount,
   output logic             busy
);

   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      PAID,
      REFUND
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [AMT_W-1:0] due_q;
   logic [AMT_W-1:0] due_d;
   logic [TW-1:0]    timer_q;
   logic [TW-1:0]    timer_d;
   logic [AMT_W-1:0] total_d;
   logic [AMT_W-1:0] change_d;
   logic [AMT_W-1:0] refund_d;
   logic             reject_d;
   logic             take;
   logic [AMT_W:0]   sum;

   assign take = note_valid && note_ready;
   assign sum  = {1'b0, paid_total} + {1'b0, note_value};

   always_comb begin
      state_d  = state_q;
      due_d    = due_q;
      timer_d  = timer_q;
      total_d  = paid_total;
      change_d = change_amount;
      refund_d = refund_amount;
      reject_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start && due_amount != '0) begin
               due_d    = due_amount;
               total_d  = '0;
               timer_d  = '0;
               change_d = '0;
               refund_d = '0;
               state_d  = COLLECT;
            end
         end
         COLLECT: begin
            if (cancel) begin
               // a note colliding with cancel is handed back, not banked
               reject_d = take;
               refund_d = paid_total;
               state_d  = REFUND;
            end else if (take) begin
               timer_d = '0;
               if (note_value == '0 || sum[AMT_W]) begin
                  reject_d = 1'b1;
               end else begin
                  total_d = sum[AMT_W-1:0];
                  if (sum[AMT_W-1:0] >= due_q) begin
                     change_d = sum[AMT_W-1:0] - due_q;
                     state_d  = PAID;
                  end
               end
            end else if (timer_q == LAST) begin
               refund_d = paid_total;
               state_d  = REFUND;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         PAID:    state_d = IDLE;
         REFUND:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         due_q            <= '0;
         timer_q          <= '0;
         paid_total       <= '0;
         change_amount    <= '0;
         refund_amount    <= '0;
         note_ready       <= 1'b0;
         note_reject      <= 1'b0;
         validate_payment <= 1'b0;
         payment_failed   <= 1'b0;
         busy             <= 1'b0;
      end else begin
         state_q          <= state_d;
         due_q            <= due_d;
         timer_q          <= timer_d;
         paid_total       <= total_d;
         change_amount    <= change_d;
         refund_amount    <= refund_d;
         note_ready       <= (state_d == COLLECT);
         note_reject      <= reject_d;
         validate_payment <= (state_d == PAID);
         payment_failed   <= (state_d == REFUND);
         busy             <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_atp_payment_accumulator.sv
// Randomized and directed bench for atp_payment_accumulator against a
// transaction-level model of the payment session.
module tb_atp_payment_accumulator;

   localparam int AMT_W = 16;
   localparam int TO    = 20;
   localparam int MAXV  = (1 << AMT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [AMT_W-1:0] due_amount;
   logic             cancel;
   logic             note_valid;
   logic [AMT_W-1:0] note_value;
   logic             note_ready;
   logic             note_reject;
   logic [AMT_W-1:0] paid_total;
   logic             validate_payment;
   logic             payment_failed;
   logic [AMT_W-1:0] change_amount;
   logic [AMT_W-1:0] refund_amount;
   logic             busy;

   int n_checks = 0;
   int n_fail   = 0;

   // session model
   bit m_coll, m_wrap, m_valid, m_fail, m_reject;
   int m_total, m_due, m_idle, m_change, m_refund;

   atp_payment_accumulator #(.AMT_W(AMT_W), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .due_amount(due_amount),
      .cancel(cancel), .note_valid(note_valid), .note_value(note_value),
      .note_ready(note_ready), .note_reject(note_reject),
      .paid_total(paid_total), .validate_payment(validate_payment),
      .payment_failed(payment_failed), .change_amount(change_amount),
      .refund_amount(refund_amount), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model(input bit r, input bit s, input int d,
                        input bit c, input bit v, input int val);
      m_valid  = 0;
      m_fail   = 0;
      m_reject = 0;
      if (r) begin
         m_coll = 0; m_wrap = 0; m_total = 0;
         m_change = 0; m_refund = 0; m_idle = 0;
      end else if (m_coll) begin
         if (c) begin
            m_reject = v;
            m_fail = 1; m_refund = m_total;
         end else if (v) begin
            m_idle = 0;
            if (val == 0 || m_total + val > MAXV) m_reject = 1;
            else begin
               m_total += val;
               if (m_total >= m_due) begin
                  m_valid = 1; m_change = m_total - m_due;
               end
            end
         end else if (m_idle == TO - 1) begin
            m_fail = 1; m_refund = m_total;
         end else m_idle++;
         if (m_valid || m_fail) begin
            m_coll = 0; m_wrap = 1;
         end
      end else if (m_wrap) begin
         m_wrap = 0;
      end else if (s && d != 0) begin
         m_coll = 1; m_due = d; m_total = 0;
         m_idle = 0; m_change = 0; m_refund = 0;
      end
   endtask

   task automatic step(input bit r, input bit s, input int d,
                       input bit c, input bit v, input int val);
      rst = r; start = s; due_amount = AMT_W'(d);
      cancel = c; note_valid = v; note_value = AMT_W'(val);
      @(posedge clk);
      model(r, s, d, c, v, val);
      #1;
      chk("note_ready", int'(note_ready), int'(m_coll));
      chk("busy", int'(busy), int'(m_coll || m_wrap));
      chk("validate", int'(validate_payment), int'(m_valid));
      chk("failed", int'(payment_failed), int'(m_fail));
      chk("reject", int'(note_reject), int'(m_reject));
      chk("paid_total", int'(paid_total), m_total);
      chk("change", int'(change_amount), m_change);
      chk("refund", int'(refund_amount), m_refund);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic begin_pay(input int d);
      step(0, 1, d, 0, 0, 0);
   endtask

   task automatic note(input int v);
      step(0, 0, 0, 0, 1, v);
   endtask

   initial begin
      int k;
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 500, 0, 1, 100);
      chk("rst_busy", int'(busy), 0);
      chk("rst_total", int'(paid_total), 0);

      // exact pay
      begin_pay(500);
      note(200); note(200); note(100);
      chk("exact_valid", int'(validate_payment), 1);
      chk("exact_change", int'(change_amount), 0);
      chk("exact_total", int'(paid_total), 500);
      idle(1);
      chk("exact_busy_fall", int'(busy), 0);

      // overpay
      begin_pay(350);
      note(200); note(500);
      chk("over_change", int'(change_amount), 350);
      chk("over_ready", int'(note_ready), 0);
      idle(1);

      // cancel collides with a note
      begin_pay(1000);
      note(500);
      step(0, 0, 0, 1, 1, 200);
      chk("cancel_reject", int'(note_reject), 1);
      chk("cancel_refund", int'(refund_amount), 500);
      idle(1);

      // timeout with no notes
      begin_pay(100);
      k = 0;
      for (int i = 1; i <= 2 * TO && k == 0; i++) begin
         idle(1);
         if (payment_failed) k = i;
      end
      chk("timeout_cycles", k, TO);
      chk("timeout_refund", int'(refund_amount), 0);
      idle(1);

      // note at cycle 15 restarts the timeout
      begin_pay(100);
      idle(14);
      note(50);
      k = 0;
      for (int i = 1; i <= 2 * TO && k == 0; i++) begin
         idle(1);
         if (payment_failed) k = i;
      end
      chk("timeout_restart", k, TO);
      chk("timeout_refund50", int'(refund_amount), 50);
      idle(1);

      // zero-value note, then overflow
      begin_pay(100);
      note(0);
      chk("zero_reject", int'(note_reject), 1);
      note(100);
      idle(1);
      begin_pay(65535);
      note(60000); note(10000);
      chk("ovf_reject", int'(note_reject), 1);
      chk("ovf_total", int'(paid_total), 60000);
      step(0, 0, 0, 1, 0, 0);
      idle(1);

      // reset mid-collect, ignored starts
      begin_pay(1000);
      note(300);
      step(1, 0, 0, 0, 0, 0);
      chk("midrst_total", int'(paid_total), 0);
      chk("midrst_failed", int'(payment_failed), 0);
      begin_pay(500);
      begin_pay(20);
      note(20);
      chk("busy_start_ign", int'(validate_payment), 0);
      step(0, 0, 0, 1, 0, 0);
      idle(1);
      begin_pay(0);
      chk("zero_due_ign", int'(busy), 0);

      // randomized sessions
      for (int e = 0; e < 40; e++) begin
         int pn = $urandom_range(2, 12);
         for (int i = 0; i < 80; i++) begin
            bit r  = ($urandom_range(0, 299) == 0);
            bit s  = ($urandom_range(0, 3) == 0);
            int d  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3000);
            bit c  = ($urandom_range(0, 59) == 0);
            bit v  = ($urandom_range(0, pn - 1) == 0);
            int sel = $urandom_range(0, 9);
            int val = (sel == 0) ? 0 :
                      (sel == 1) ? $urandom_range(40000, MAXV) :
                      $urandom_range(1, 800);
            if (e == 7) d = $urandom_range(50000, MAXV);
            step(r, s, d, c, v, val);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
